// File: rtl/aether_uart_rx.sv
// Oversampling UART receiver with glitch rejection, framing/overrun detection and a receive FIFO.
// Optional parity bit compiled in with `define AETHER_UART_RX_PARITY_EN.
module aether_uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  input  logic                          parity_odd,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS);
  localparam int PW    = $clog2(FIFO_DEPTH);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST      = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BC_W-1:0]  BC_LAST      = BC_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef AETHER_UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // ---------------------------------------------------------------------------
  // Free-running oversample tick generator
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser, reset to the idle-high line level
  // ---------------------------------------------------------------------------
  logic [1:0] sync;
  logic       rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], uart_rx};
    end
  end

  assign rxs = sync[1];

  // ---------------------------------------------------------------------------
  // Deframing FSM
  // ---------------------------------------------------------------------------
  logic [2:0]           state;
  logic [OS_W-1:0]      os_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 armed;
  logic                 par_bad;
  logic                 stop_sample;
  logic                 push_req;

  assign busy        = (state != S_IDLE);
  assign stop_sample = (state == S_STOP) && tick && (os_cnt == OS_LAST);
  assign push_req    = stop_sample && rxs && !par_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      armed     <= 1'b1;
      frame_err <= 1'b0;
`ifdef AETHER_UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef AETHER_UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          // After a framing error the line must go high before a new start is accepted.
          if (!armed) begin
            if (rxs) armed <= 1'b1;
          end else if (tick && !rxs) begin
            os_cnt <= '0;
            state  <= S_START;
          end
        end

        S_START: begin
          if (tick) begin
            if (os_cnt == OS_HALF_LAST) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              state   <= rxs ? S_IDLE : S_DATA;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              shreg  <= {rxs, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BC_LAST) begin
`ifdef AETHER_UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

`ifdef AETHER_UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt  <= '0;
              par_bad <= rxs ^ (^shreg) ^ parity_odd;
              state   <= S_STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
`endif

        S_STOP: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              state  <= S_IDLE;
              if (!rxs) begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end
`ifdef AETHER_UART_RX_PARITY_EN
              else if (par_bad) begin
                parity_err <= 1'b1;
              end
`endif
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef AETHER_UART_RX_PARITY_EN
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign par_bad           = 1'b0;
  assign parity_err        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Receive FIFO with registered head and valid
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW:0]          wr_ptr;
  logic [PW:0]          rd_ptr;
  logic [PW:0]          wr_nxt;
  logic [PW:0]          rd_nxt;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic [DATA_BITS-1:0] head_nxt;

  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop        = rd_valid && rd_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign push       = push_req && (!full || pop);
  assign wr_nxt     = wr_ptr + (PW+1)'(push);
  assign rd_nxt     = rd_ptr + (PW+1)'(pop);
  assign fifo_count = wr_ptr - rd_ptr;

  always_comb begin
    head_nxt = '0;
    if (wr_nxt != rd_nxt) begin
      if (push && (wr_ptr[PW-1:0] == rd_nxt[PW-1:0])) begin
        head_nxt = shreg;
      end else begin
        head_nxt = mem[rd_nxt[PW-1:0]];
      end
    end
  end

  // NOTE: storage has no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= shreg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overrun  <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      rd_valid <= (wr_nxt != rd_nxt);
      rd_data  <= head_nxt;
      overrun  <= push_req && full && !pop;
    end
  end

endmodule

// File: tb/tb_aether_uart_rx.sv
// Directed self-checking bench for aether_uart_rx at 160 clocks per bit, 4-entry FIFO.
// Parity scenario runs when AETHER_UART_RX_PARITY_EN is defined.
module tb_aether_uart_rx;

  localparam int BIT_CYC = 160;
`ifdef AETHER_UART_RX_PARITY_EN
  localparam int PUSH_OFFSET = 1679;
`else
  localparam int PUSH_OFFSET = 1519;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       parity_odd;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] fifo_count;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int n_cmp  = 0;
  int n_fail = 0;
  int fe_n   = 0;
  int pe_n   = 0;
  int ov_n   = 0;

  aether_uart_rx #(
    .CLK_FREQ  (100_000_000),
    .BAUD      (625_000),
    .OVERSAMPLE(16),
    .DATA_BITS (8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .parity_odd(parity_odd),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .fifo_count(fifo_count),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err)  fe_n++;
      if (parity_err) pe_n++;
      if (overrun)    ov_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef AETHER_UART_RX_PARITY_EN
    drive_bit((^d) ^ parity_odd);
`endif
    drive_bit(stop_bit);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

`ifdef AETHER_UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par_bit);
    drive_bit(1'b1);
    repeat (20) @(negedge clk);
  endtask
`endif

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, rd_data, exp);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int waited;
    logic [7:0] ch;

    rst        = 1'b1;
    uart_rx    = 1'b1;
    rd_ready   = 1'b0;
    parity_odd = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_rd_valid", rd_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_overrun", overrun, 0);

    // Single character, held until popped
    send_frame(8'h41, 1'b1);
    check("t1_rd_valid", rd_valid, 1);
    check("t1_rd_data", rd_data, 8'h41);
    check("t1_fifo_count", fifo_count, 1);
    check("t1_no_errors", fe_n + pe_n + ov_n, 0);
    pop_check("t1_pop", 8'h41);
    check("t1_rd_valid_after_pop", rd_valid, 0);
    check("t1_count_after_pop", fifo_count, 0);

    // 40-cycle low glitch is rejected
    uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    check("t2_busy", busy, 0);
    check("t2_fifo_count", fifo_count, 0);
    check("t2_no_errors", fe_n + pe_n + ov_n, 0);

    // Framing error, then recovery
    send_frame(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("t3_frame_err_pulses", fe_n, 1);
    check("t3_fifo_count", fifo_count, 0);
    send_frame(8'hA3, 1'b1);
    check("t3_recover_data", rd_data, 8'hA3);
    check("t3_recover_count", fifo_count, 1);
    check("t3_frame_err_pulses_after", fe_n, 1);
    pop_check("t3_pop", 8'hA3);

    // Overrun on the fifth character with no consumer
    for (int i = 1; i <= 5; i++) begin
      ch = 8'(i);
      send_frame(ch, 1'b1);
    end
    check("t4_fifo_count", fifo_count, 4);
    check("t4_overrun_pulses", ov_n, 1);
    for (int i = 1; i <= 4; i++) begin
      ch = 8'(i);
      pop_check("t4_pop_order", ch);
    end
    check("t4_count_drained", fifo_count, 0);

    // Full FIFO, pop coincides with the fifth push
    for (int i = 0; i < 4; i++) begin
      ch = 8'h11 + 8'(i);
      send_frame(ch, 1'b1);
    end
    check("t5_full_count", fifo_count, 4);
    waited = 0;
    fork
      send_frame(8'h15, 1'b1);
      begin
        while (!busy && waited < 400) begin
          @(negedge clk);
          waited++;
        end
        check("t5_busy_rise", busy, 1);
        repeat (PUSH_OFFSET) @(negedge clk);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
      end
    join
    check("t5_no_overrun", ov_n, 1);
    check("t5_fifo_count", fifo_count, 4);
    check("t5_head_advanced", rd_data, 8'h12);
    for (int i = 0; i < 4; i++) begin
      ch = 8'h12 + 8'(i);
      pop_check("t5_pop_order", ch);
    end
    check("t5_count_drained", fifo_count, 0);

`ifdef AETHER_UART_RX_PARITY_EN
    // Even parity: good then bad parity bit
    parity_odd = 1'b0;
    send_frame_par(8'h07, 1'b1);
    check("t6_good_count", fifo_count, 1);
    check("t6_good_data", rd_data, 8'h07);
    check("t6_good_no_perr", pe_n, 0);
    send_frame_par(8'h07, 1'b0);
    check("t6_parity_err_pulses", pe_n, 1);
    check("t6_bad_not_stored", fifo_count, 1);
    pop_check("t6_pop", 8'h07);
`else
    check("t6_parity_err_tied", pe_n, 0);
`endif

    // Reset during DATA with a character already buffered
    send_frame(8'h66, 1'b1);
    check("t7_pre_count", fifo_count, 1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("t7_busy_mid_frame", busy, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("t7_rd_valid", rd_valid, 0);
    check("t7_fifo_count", fifo_count, 0);
    check("t7_busy", busy, 0);
    check("t7_rd_data", rd_data, 0);
    check("t7_pulses_low", {frame_err, parity_err, overrun}, 0);
    repeat (200) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    check("t7_after_data", rd_data, 8'h3C);
    check("t7_after_count", fifo_count, 1);
`ifdef AETHER_UART_RX_PARITY_EN
    check("t7_error_totals", {fe_n[7:0], pe_n[7:0], ov_n[7:0]}, {8'd1, 8'd1, 8'd1});
`else
    check("t7_error_totals", {fe_n[7:0], pe_n[7:0], ov_n[7:0]}, {8'd1, 8'd0, 8'd1});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aether_uart_rx.md
# aether_uart_rx

Parametrised UART receiver for the Aether SoC peripheral bus, successor to the fixed 9600-baud 8N1 receive path. It oversamples `uart_rx`, deframes configurable-width characters with glitch rejection and error detection, and buffers them in an internal FIFO drained over a valid/ready handshake. It sits between the `uart_rx` pad and the UART register block.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 9600, line rate in bit/s
- `OVERSAMPLE`, 16, sample ticks per bit; even, ≥ 4
- `DATA_BITS`, 8, character width, 5..9
- `FIFO_DEPTH`, 8, receive FIFO entries; power of two, ≥ 2
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `uart_rx`  in  1  serial line, idle high, asynchronous to `clk`
- `parity_odd`  in  1  1 = odd parity, 0 = even; ignored unless parity is compiled in
- `rd_data`  out  DATA_BITS  FIFO head character, LSB = first bit received
- `rd_valid`  out  1  FIFO non-empty
- `rd_ready`  in  1  consumer pops the head when `rd_valid & rd_ready`
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy
- `busy`  out  1  FSM is not in IDLE
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `parity_err`  out  1  one-cycle pulse: parity mismatch; constant 0 without the macro
- `overrun`  out  1  one-cycle pulse: character completed while FIFO full

## Operation
- Tick generator: `DIV = CLK_FREQ/(BAUD*OVERSAMPLE)`, integer division, truncated. The counter counts 0..DIV-1 and pulses `tick` on wrap. It runs freely and is never resynchronised.
- Input synchroniser: two flops, both reset to 1. The FSM sees only the synchronised value `rxs`.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: on the first tick with `rxs`=0, clear the tick counter and enter START.
  - START: after OVERSAMPLE/2 ticks, sample `rxs`. If 1, treat it as a glitch and return to IDLE with no flags. If 0, enter DATA.
  - DATA: sample every OVERSAMPLE ticks and shift LSB-first. After DATA_BITS samples, enter PARITY if the macro is defined, otherwise STOP.
  - PARITY: one sample after OVERSAMPLE ticks, then enter STOP.
  - STOP: one sample after OVERSAMPLE ticks.
    - Sample 0: pulse `frame_err`, discard the character, return to IDLE. The next start is detected only once `rxs` has returned high and falls again.
    - Sample 1 with parity mismatch: pulse `parity_err`, discard the character.
    - Sample 1 otherwise: push the character to the FIFO. If the FIFO is full, drop the character and pulse `overrun`. Existing contents are kept.
- FIFO: circular buffer with $clog2(FIFO_DEPTH)+1-bit pointers. The pointers wrap modulo 2·FIFO_DEPTH; full/empty are decided by comparing the MSBs.
  - Pop when `rd_valid & rd_ready`.
  - Push and pop in the same cycle: both happen and `fifo_count` is unchanged. When full, the pop frees the slot and the push is accepted, so `overrun` stays low.
  - `rd_ready` while empty has no effect.
- Only one error flag pulses per character. Precedence: frame > parity > overrun.

## Timing
- Reset values:
  - Outputs: `rd_valid`=0, `fifo_count`=0, `busy`=0, all error pulses 0, `rd_data`=0.
  - Internal: FSM in IDLE, pointers 0, tick counter 0, synchroniser flops 1.
- Reset mid-frame aborts the frame and empties the FIFO. No flag is produced.
- `rd_data` and `rd_valid` are registered.
- A push is visible on `rd_valid` and `fifo_count` one cycle after the STOP sample cycle.
- A pop updates `rd_data` and `fifo_count` on the next clock edge.
- Error pulses are asserted in the cycle after the deciding sample.
- Start-edge detection latency is the 2 synchroniser cycles plus up to one tick.
- Each bit is sampled nominally at mid-bit, OVERSAMPLE·DIV cycles apart.

## Configuration
- `AETHER_UART_RX_PARITY_EN`:
  - Defined: the frame includes one parity bit after the data bits, checked against `parity_odd`. Parity is the XOR of the data bits; `parity_odd`=1 inverts the expected value. A mismatch discards the character and pulses `parity_err`.
  - Undefined: the PARITY state and its logic are absent, the frame is start/data/stop, `parity_err` is tied 0 and `parity_odd` is unused.

## Test plan
All scenarios use CLK_FREQ=100e6 and BAUD=625_000, giving DIV=10 and 160 cycles per bit; DATA_BITS=8, FIFO_DEPTH=4.
- Send 0x41 8N1, with `rd_ready`=0. Required: `rd_valid`=1, `rd_data`=0x41, `fifo_count`=1, no error pulses. Then pulse `rd_ready` for one cycle: `rd_valid`=0, `fifo_count`=0.
- Drive a 40-cycle low glitch on `uart_rx`. Required: FSM returns to IDLE, `busy` falls, no flags, `fifo_count` stays 0.
- Send 0x55 with the stop bit driven low. Required: one `frame_err` pulse, `fifo_count`=0. A following 0xA3 frame is received correctly.
- With `rd_ready`=0, send 0x01..0x05. Required: `fifo_count`=4, one `overrun` pulse on the 5th character. Popping then yields 0x01..0x04 in order.
- With the FIFO full, hold `rd_ready`=1 for the cycle the 5th character pushes. Required: no `overrun`, `fifo_count` stays 4, and the head advances.
- With `AETHER_UART_RX_PARITY_EN` and `parity_odd`=0, send 0x07 with parity bit 1 (accepted) and then 0x07 with parity bit 0. Required: the second character gives one `parity_err` pulse and is not stored.
- Reset mid-DATA after 3 bits. Required: all outputs return to their reset values, and the next full 0x3C frame is received cleanly.
